// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Purpose:
//   Single-outstanding-request controller in front of a cache and main memory.
//   Loads that hit return cache data. Loads that miss fetch from memory and
//   fill the cache (read-allocate). Stores are write-allocate into the cache
//   and write-through to memory. The controller also keeps saturating
//   hit/miss counters for loads.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request (accepted only in IDLE)
//   cpu_rdata, cpu_ready   load data and one-cycle completion pulse
//   cache_addr/wdata/we    cache access (address from the latched request)
//   cache_hit, cache_rdata cache lookup result for cache_addr
//   mem_req/we/addr/wdata  main-memory request, held until mem_ack
//   mem_ack, mem_rdata     memory completion and read data
//   hit_count, miss_count  saturating load statistics
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [DATA_WIDTH-1:0] cache_wdata,
    output logic                  cache_we,
    input  logic                  cache_hit,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_MEM_READ,
        S_FILL,
        S_MEM_WRITE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_fill;
    logic [CNT_WIDTH-1:0]  r_hit_count;
    logic [CNT_WIDTH-1:0]  r_miss_count;

    logic                  w_accept;
    logic                  w_load_hit;
    logic                  w_load_miss;

    assign w_accept    = (r_state == S_IDLE) && cpu_req;
    assign w_load_hit  = (r_state == S_COMPARE) && !r_we && cache_hit;
    assign w_load_miss = (r_state == S_COMPARE) && !r_we && !cache_hit;

    // State register. Reset forces IDLE at once, which in turn drops
    // mem_req/cache_we/cpu_ready through the combinational decode below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request registers: the only source for cache/memory addresses and
    // write data, so the CPU is free to change its inputs after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= cpu_addr;
            r_we    <= cpu_we;
            r_wdata <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if ((r_state == S_MEM_READ) && mem_ack) begin
            r_fill <= mem_rdata;
        end
    end

    // Saturating statistics; stores never reach these conditions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_load_hit && (r_hit_count != {CNT_WIDTH{1'b1}})) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            if (w_load_miss && (r_miss_count != {CNT_WIDTH{1'b1}})) begin
                r_miss_count <= r_miss_count + 1'b1;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next = r_state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        cache_we     = 1'b0;
        cache_wdata  = '0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    w_state_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (r_we) begin
                    // Write-allocate: the line is written whether or not it hit.
                    cache_we     = 1'b1;
                    cache_wdata  = r_wdata;
                    w_state_next = S_MEM_WRITE;
                end else if (cache_hit) begin
                    cpu_ready    = 1'b1;
                    cpu_rdata    = cache_rdata;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                cache_we     = 1'b1;
                cache_wdata  = r_fill;
                cpu_ready    = 1'b1;
                cpu_rdata    = r_fill;
                w_state_next = S_IDLE;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    cpu_ready    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign cache_addr = r_addr;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
//
// Purpose:
//   Self-checking bench for cache_controller (CNT_WIDTH=4). A cycle-by-cycle
//   vector table covers load hit, load miss with fill, store write-through,
//   ignored requests/acks and back-to-back requests; hand-written sequences
//   cover reset in the middle of a miss and counter saturation.
// -----------------------------------------------------------------------------
module tb_cache_controller;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 4;
    localparam int NV = 20;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;
    logic [AW-1:0] cache_addr;
    logic [DW-1:0] cache_wdata;
    logic          cache_we;
    logic          cache_hit;
    logic [DW-1:0] cache_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int checks   = 0;
    int failures = 0;

    cache_controller #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .cache_addr (cache_addr),
        .cache_wdata(cache_wdata),
        .cache_we   (cache_we),
        .cache_hit  (cache_hit),
        .cache_rdata(cache_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic          req;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          chit;
        logic [31:0]   crdata;
        logic          ack;
        logic [31:0]   mrdata;
        logic          rdy;
        logic [31:0]   rdata;
        logic          cwe;
        logic [31:0]   cwdata;
        logic [31:0]   caddr;
        logic          mreq;
        logic          mwe;
        logic [31:0]   mwdata;
        logic [3:0]    hit;
        logic [3:0]    miss;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
        input logic chit, input logic [31:0] crdata, input logic ack, input logic [31:0] mrdata,
        input logic rdy, input logic [31:0] rdata, input logic cwe, input logic [31:0] cwdata,
        input logic [31:0] caddr, input logic mreq, input logic mwe, input logic [31:0] mwdata,
        input logic [3:0] hit, input logic [3:0] miss);
        vec_t v;
        v.req = req;   v.we = we;     v.addr = addr;   v.wdata = wdata;
        v.chit = chit; v.crdata = crdata; v.ack = ack; v.mrdata = mrdata;
        v.rdy = rdy;   v.rdata = rdata; v.cwe = cwe;   v.cwdata = cwdata;
        v.caddr = caddr; v.mreq = mreq; v.mwe = mwe;   v.mwdata = mwdata;
        v.hit = hit;   v.miss = miss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cache_hit   = 1'b0;
        cache_rdata = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
    endtask

    // Load that hits: request, then COMPARE cycle, then the updated counter.
    task automatic do_load_hit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] exp_hit);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a; cache_hit = 1'b1; cache_rdata = d;
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        chk("hit_ready", {31'b0, cpu_ready}, 32'h1);
        chk("hit_rdata", cpu_rdata, d);
        @(negedge clk);
        #1;
        chk("hit_count", {28'b0, hit_count}, {28'b0, exp_hit});
        $display("load hit addr=0x%08h data=0x%08h hit_count=%0d", a, d, hit_count);
    endtask

    initial begin
        logic [3:0] exp_hit;

        //          req we  addr          wdata         chit crdata        ack mrdata        rdy rdata         cwe cwdata        caddr         mreq mwe mwdata     hit   miss
        vecs[0]  = mk(1, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 32'h0,        4'd0, 4'd0);
        vecs[1]  = mk(0, 0, 32'h10,       32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,        32'h10,       0, 0, 32'h0,        4'd0, 4'd0);
        vecs[2]  = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h10,       0, 0, 32'h0,        4'd1, 4'd0);
        vecs[3]  = mk(1, 0, 32'h20,       32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h10,       0, 0, 32'h0,        4'd1, 4'd0);
        vecs[4]  = mk(0, 0, 32'h20,       32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h20,       0, 0, 32'h0,        4'd1, 4'd0);
        vecs[5]  = mk(0, 0, 32'h20,       32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 32'h0,        4'd1, 4'd1);
        vecs[6]  = mk(1, 1, 32'h99,       32'hFFFFFFFF, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 32'h0,        4'd1, 4'd1);
        vecs[7]  = mk(0, 0, 32'h99,       32'h0,        0, 32'h0,        1, 32'h12345678, 0, 32'h0,        0, 32'h0,        32'h20,       1, 0, 32'h0,        4'd1, 4'd1);
        vecs[8]  = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h12345678, 1, 32'h12345678, 32'h20,       0, 0, 32'h0,        4'd1, 4'd1);
        vecs[9]  = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h20,       0, 0, 32'h0,        4'd1, 4'd1);
        vecs[10] = mk(1, 1, 32'h40,       32'hA5A5A5A5, 0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h20,       0, 0, 32'h0,        4'd1, 4'd1);
        vecs[11] = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'hA5A5A5A5, 32'h40,       0, 0, 32'hA5A5A5A5, 4'd1, 4'd1);
        vecs[12] = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       1, 1, 32'hA5A5A5A5, 4'd1, 4'd1);
        vecs[13] = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h0,        0, 32'h0,        32'h40,       1, 1, 32'hA5A5A5A5, 4'd1, 4'd1);
        vecs[14] = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       0, 0, 32'hA5A5A5A5, 4'd1, 4'd1);
        vecs[15] = mk(1, 0, 32'h50,       32'h0,        1, 32'hCAFEF00D, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h40,       0, 0, 32'hA5A5A5A5, 4'd1, 4'd1);
        vecs[16] = mk(1, 0, 32'h60,       32'h0,        1, 32'hCAFEF00D, 0, 32'h0,        1, 32'hCAFEF00D, 0, 32'h0,        32'h50,       0, 0, 32'h0,        4'd1, 4'd1);
        vecs[17] = mk(1, 0, 32'h60,       32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h50,       0, 0, 32'h0,        4'd2, 4'd1);
        vecs[18] = mk(0, 0, 32'h0,        32'h0,        1, 32'h11112222, 0, 32'h0,        1, 32'h11112222, 0, 32'h0,        32'h60,       0, 0, 32'h0,        4'd2, 4'd1);
        vecs[19] = mk(0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h60,       0, 0, 32'h0,        4'd3, 4'd1);

        // Reset state
        rst = 1'b1;
        drive_idle();
        #12;
        chk("rst_ready",   {31'b0, cpu_ready}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req},   32'h0);
        chk("rst_cache_we",{31'b0, cache_we},  32'h0);
        chk("rst_hit",     {28'b0, hit_count}, 32'h0);
        chk("rst_miss",    {28'b0, miss_count},32'h0);
        chk("rst_addr",    cache_addr,         32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: inputs applied just after the falling edge, outputs sampled 1ns later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            cpu_req     = vecs[i].req;
            cpu_we      = vecs[i].we;
            cpu_addr    = vecs[i].addr;
            cpu_wdata   = vecs[i].wdata;
            cache_hit   = vecs[i].chit;
            cache_rdata = vecs[i].crdata;
            mem_ack     = vecs[i].ack;
            mem_rdata   = vecs[i].mrdata;
            #1;
            chk($sformatf("v%0d_ready", i),  {31'b0, cpu_ready},  {31'b0, vecs[i].rdy});
            chk($sformatf("v%0d_rdata", i),  cpu_rdata,           vecs[i].rdata);
            chk($sformatf("v%0d_cwe", i),    {31'b0, cache_we},   {31'b0, vecs[i].cwe});
            chk($sformatf("v%0d_cwdata", i), cache_wdata,         vecs[i].cwdata);
            chk($sformatf("v%0d_caddr", i),  cache_addr,          vecs[i].caddr);
            chk($sformatf("v%0d_maddr", i),  mem_addr,            vecs[i].caddr);
            chk($sformatf("v%0d_mreq", i),   {31'b0, mem_req},    {31'b0, vecs[i].mreq});
            chk($sformatf("v%0d_mwe", i),    {31'b0, mem_we},     {31'b0, vecs[i].mwe});
            chk($sformatf("v%0d_mwdata", i), mem_wdata,           vecs[i].mwdata);
            chk($sformatf("v%0d_hit", i),    {28'b0, hit_count},  {28'b0, vecs[i].hit});
            chk($sformatf("v%0d_miss", i),   {28'b0, miss_count}, {28'b0, vecs[i].miss});
            $display("vec %0d req=%0b we=%0b addr=0x%08h ready=%0b rdata=0x%08h mem_req=%0b hit=%0d miss=%0d",
                     i, vecs[i].req, vecs[i].we, vecs[i].addr, cpu_ready, cpu_rdata, mem_req, hit_count, miss_count);
        end

        // Reset in the middle of a miss
        @(negedge clk);
        drive_idle();
        cpu_req = 1'b1; cpu_addr = 32'h70;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_mem_req_before", {31'b0, mem_req}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_mem_req_rst", {31'b0, mem_req},    32'h0);
        chk("mid_ready_rst",   {31'b0, cpu_ready},  32'h0);
        chk("mid_hit_rst",     {28'b0, hit_count},  32'h0);
        chk("mid_miss_rst",    {28'b0, miss_count}, 32'h0);
        chk("mid_addr_rst",    mem_addr,            32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        #1;
        chk("stray_ack_ready0",   {31'b0, cpu_ready}, 32'h0);
        chk("stray_ack_mem_req0", {31'b0, mem_req},   32'h0);
        @(negedge clk);
        #1;
        chk("stray_ack_ready1",   {31'b0, cpu_ready}, 32'h0);
        chk("stray_ack_cwe1",     {31'b0, cache_we},  32'h0);
        $display("reset mid-miss: mem_req=%0b ready=%0b miss=%0d", mem_req, cpu_ready, miss_count);
        drive_idle();

        // Saturation: 17 hits from zero on a 4-bit counter
        exp_hit = 4'd0;
        for (int i = 0; i < 17; i++) begin
            exp_hit = (exp_hit == 4'hF) ? 4'hF : exp_hit + 4'd1;
            do_load_hit(32'h100 + 32'(i * 4), 32'h0BAD0000 + 32'(i), exp_hit);
        end
        chk("sat_hit_final",  {28'b0, hit_count},  32'hF);
        chk("sat_miss_final", {28'b0, miss_count}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning data word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 16, meaning hit/miss counter width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port cpu_req, input, 1 bit: CPU access request.
REQ-007 The module SHALL have port cpu_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The module SHALL have port cpu_addr, input, ADDR_WIDTH: access address.
REQ-009 The module SHALL have port cpu_wdata, input, DATA_WIDTH: store data.
REQ-010 The module SHALL have port cpu_rdata, output, DATA_WIDTH: load data, valid while cpu_ready=1 on a load.
REQ-011 The module SHALL have port cpu_ready, output, 1 bit: one-cycle completion pulse.
REQ-012 The module SHALL have port cache_addr, output, ADDR_WIDTH: address driven to the cache.
REQ-013 The module SHALL have port cache_wdata, output, DATA_WIDTH: cache write data.
REQ-014 The module SHALL have port cache_we, output, 1 bit: cache write enable.
REQ-015 The module SHALL have port cache_hit, input, 1 bit: cache hit for cache_addr.
REQ-016 The module SHALL have port cache_rdata, input, DATA_WIDTH: cache read data.
REQ-017 The module SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_WIDTH) and mem_wdata (output, DATA_WIDTH): the main-memory request.
REQ-018 The module SHALL have ports mem_ack (input, 1) and mem_rdata (input, DATA_WIDTH): memory completion and read data.
REQ-019 The module SHALL have ports hit_count and miss_count, both output, CNT_WIDTH: load hit and miss statistics.

Function
REQ-020 FSM states SHALL be IDLE, COMPARE, MEM_READ, FILL and MEM_WRITE.
REQ-021 IDLE: cpu_req=1 at a clock edge SHALL latch cpu_addr/cpu_we/cpu_wdata into request registers and move to COMPARE; cpu_req is ignored in all other states.
REQ-022 cache_addr, mem_addr and mem_wdata SHALL always be driven from the latched request registers.
REQ-023 COMPARE, load, cache_hit=1: cpu_ready=1 and cpu_rdata=cache_rdata in that cycle; hit_count increments; next state IDLE.
REQ-024 COMPARE, load, cache_hit=0: miss_count increments; next state MEM_READ.
REQ-025 COMPARE, store: cache_we=1 and cache_wdata=latched wdata (write-allocate, hit or miss); next state MEM_WRITE.
REQ-026 MEM_READ: mem_req=1 and mem_we=0 SHALL be held until mem_ack=1; on ack, capture mem_rdata into a fill register and move to FILL.
REQ-027 FILL: cache_we=1, cache_wdata=fill register, cpu_ready=1, cpu_rdata=fill register; next state IDLE.
REQ-028 MEM_WRITE (write-through): mem_req=1 and mem_we=1 SHALL be held until mem_ack=1; in the ack cycle cpu_ready=1; next state IDLE.
REQ-029 mem_ack outside MEM_READ/MEM_WRITE SHALL be ignored.
REQ-030 Latency from the request edge: load hit cpu_ready in the next cycle; load miss cpu_ready one cycle after the mem_ack cycle; store cpu_ready in the mem_ack cycle.
REQ-031 Counters SHALL saturate at all-ones and never wrap; stores SHALL not count.
REQ-032 Outside the states named above, cpu_ready, cache_we and mem_req SHALL be 0, and cpu_rdata SHALL be 0 whenever cpu_ready=0.
REQ-033 A back-to-back cpu_req held high SHALL be accepted in the IDLE cycle following the cpu_ready cycle.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE and force mem_req, cache_we and cpu_ready to 0, including in the middle of a transaction; the pending access is discarded.
REQ-035 Reset SHALL clear hit_count, miss_count, the request registers and the fill register to 0.

Verification
REQ-036 Load hit: reset; load 0x10, cache_hit=1, cache_rdata=0xDEADBEEF -> cpu_ready next cycle, cpu_rdata=0xDEADBEEF, hit_count=1, mem_req never 1.
REQ-037 Load miss: load 0x20, cache_hit=0, mem_ack after 3 cycles with mem_rdata=0x12345678 -> cache_we=1 and cpu_ready=1 in FILL with data 0x12345678, miss_count=1.
REQ-038 Store: store 0x40 with data 0xA5A5A5A5 -> cache_we in COMPARE; mem_req=1, mem_we=1, mem_addr=0x40 held until ack; cpu_ready in the ack cycle; counters unchanged.
REQ-039 Reset mid-miss: assert rst while in MEM_READ -> mem_req=0 immediately; after release, state IDLE, counters 0, a stray mem_ack produces no cpu_ready.
REQ-040 Saturation: preload hit_count to all-ones via 2^CNT_WIDTH hits (CNT_WIDTH=4 bench) -> one further hit leaves it at 0xF.
REQ-041 Input stability: change cpu_addr during MEM_READ -> mem_addr holds the latched value.
